lbist_ctrl: RTL and testbench

LBIST_CTRL -- requirements
Module: lbist_ctrl

---
 rtl/lbist_pkg.sv | 25 ++
 rtl/lbist_if.sv | 25 ++
 rtl/lbist_misr.sv | 40 ++++
 rtl/lbist_ctrl.sv | 105 ++++++++++
 tb/tb_lbist_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/lbist_pkg.sv
// Shared types and constants for the logic-BIST controller: FSM states,
// default vector widths, LFSR/MISR tap positions and the LFSR seed.
package lbist_pkg;

    localparam int PAT_W_DEF = 18;
    localparam int RSP_W_DEF = 19;

    // Stimulus LFSR: x^18 + x^11 + 1 style taps on bits 17 and 10
    localparam int LFSR_TAP_HI = 17;
    localparam int LFSR_TAP_LO = 10;
    localparam logic [PAT_W_DEF-1:0] LFSR_SEED = 18'h00001;

    localparam int MISR_TAP_3 = 18;
    localparam int MISR_TAP_2 = 5;
    localparam int MISR_TAP_1 = 1;
    localparam int MISR_TAP_0 = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/lbist_if.sv
// Handshake and data bundle between the BIST controller (slave side) and
// its host / circuit under test (master side).
interface lbist_if #(
    parameter int PAT_W = lbist_pkg::PAT_W_DEF,
    parameter int RSP_W = lbist_pkg::RSP_W_DEF
);
    logic             start;
    logic [PAT_W-1:0] pat_o;
    logic [RSP_W-1:0] rsp_i;
    logic             busy;
    logic             done;
    logic             pass;
    logic [RSP_W-1:0] signature;
    logic [15:0]      pat_cnt;

    modport slave (
        input  start, rsp_i,
        output pat_o, busy, done, pass, signature, pat_cnt
    );

    modport master (
        output start, rsp_i,
        input  pat_o, busy, done, pass, signature, pat_cnt
    );
endinterface

// File: rtl/lbist_misr.sv
// Multiple-input signature register: shifts left with XOR feedback from the
// package taps and folds the CUT response in on every enabled cycle.
module lbist_misr
    import lbist_pkg::*;
#(
    parameter int W = RSP_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] sig_o
);

    logic [W-1:0] sig_q, sig_d;
    logic         fb;

    // Clear wins over enable so INIT always starts the run from zero
    always_comb begin
        fb    = sig_q[MISR_TAP_3] ^ sig_q[MISR_TAP_2] ^ sig_q[MISR_TAP_1] ^ sig_q[MISR_TAP_0];
        sig_d = sig_q;
        if (clr_i) begin
            sig_d = '0;
        end else if (en_i) begin
            sig_d = {sig_q[W-2:0], fb} ^ data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/lbist_ctrl.sv
// Logic-BIST controller: clears the CUT, applies N_PAT LFSR patterns,
// compacts the responses in a MISR and compares against GOLDEN.
module lbist_ctrl
    import lbist_pkg::*;
#(
    parameter int               PAT_W  = PAT_W_DEF,
    parameter int               RSP_W  = RSP_W_DEF,
    parameter int               N_PAT  = 1023,
    parameter logic [RSP_W-1:0] GOLDEN = '0
) (
    input  logic  CK,
    input  logic  RST,
    lbist_if.slave bus
);

    localparam logic [15:0]      LAST_CNT  = 16'(N_PAT - 1);
    localparam logic [PAT_W-1:0] CUT_CLEAR = {1'b1, {(PAT_W-1){1'b0}}};
    localparam logic [PAT_W-1:0] SEED      = PAT_W'(LFSR_SEED);

    state_e           state_q, state_d;
    logic             initCnt_q, initCnt_d;
    logic [PAT_W-1:0] lfsr_q, lfsr_d;
    logic [15:0]      patCnt_q, patCnt_d;
    logic             misrClr, misrEn;
    logic [RSP_W-1:0] sig;

    // INIT is held for two cycles by initCnt_q so the CUT clear is seen
    // for two full clocks before the first pattern
    always_comb begin
        state_d   = state_q;
        initCnt_d = initCnt_q;
        lfsr_d    = lfsr_q;
        patCnt_d  = patCnt_q;
        misrClr   = 1'b0;
        misrEn    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d   = ST_INIT;
                    initCnt_d = 1'b0;
                end
            end
            ST_INIT: begin
                lfsr_d    = SEED;
                patCnt_d  = '0;
                misrClr   = 1'b1;
                initCnt_d = 1'b1;
                if (initCnt_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                lfsr_d   = {lfsr_q[PAT_W-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
                misrEn   = 1'b1;
                patCnt_d = patCnt_q + 16'd1;
                if (patCnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            initCnt_q <= 1'b0;
            lfsr_q    <= SEED;
            patCnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            initCnt_q <= initCnt_d;
            lfsr_q    <= lfsr_d;
            patCnt_q  <= patCnt_d;
        end
    end

    lbist_misr #(
        .W (RSP_W)
    ) u_misr (
        .clk    (CK),
        .rst    (RST),
        .clr_i  (misrClr),
        .en_i   (misrEn),
        .data_i (bus.rsp_i),
        .sig_o  (sig)
    );

    // Outputs depend only on state and registers; rsp_i reaches them via the MISR
    always_comb begin
        bus.pat_o = '0;
        if (state_q == ST_INIT) begin
            bus.pat_o = CUT_CLEAR;
        end else if (state_q == ST_RUN) begin
            bus.pat_o = lfsr_q;
        end
    end

    assign bus.busy      = (state_q == ST_INIT) || (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.pass      = (state_q == ST_DONE) && (sig == GOLDEN);
    assign bus.signature = sig;
    assign bus.pat_cnt   = patCnt_q;

endmodule

// File: tb/tb_lbist_ctrl.sv
// Directed bench for lbist_ctrl: two short-run instances (N_PAT=2) and one
// full-length instance driven by a small combinational CUT stand-in.
module tb_lbist_ctrl;

    localparam int NC = 1023;
    localparam logic [17:0] HEAD_PAT [12] = '{
        18'h00001, 18'h00002, 18'h00004, 18'h00008, 18'h00010, 18'h00020,
        18'h00040, 18'h00080, 18'h00100, 18'h00200, 18'h00400, 18'h00801
    };

    logic CK;
    logic RST;
    int   total;
    int   bad;
    logic [18:0] modelSig;
    logic [18:0] refSig;

    lbist_if #(.PAT_W(18), .RSP_W(19)) busA ();
    lbist_if #(.PAT_W(18), .RSP_W(19)) busB ();
    lbist_if #(.PAT_W(18), .RSP_W(19)) busC ();

    lbist_ctrl #(.PAT_W(18), .RSP_W(19), .N_PAT(2), .GOLDEN(19'h2)) dutA (
        .CK  (CK),
        .RST (RST),
        .bus (busA)
    );

    lbist_ctrl #(.PAT_W(18), .RSP_W(19), .N_PAT(2), .GOLDEN(19'h0)) dutB (
        .CK  (CK),
        .RST (RST),
        .bus (busB)
    );

    lbist_ctrl #(.PAT_W(18), .RSP_W(19), .N_PAT(NC), .GOLDEN(19'h0)) dutC (
        .CK  (CK),
        .RST (RST),
        .bus (busC)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    function automatic logic [18:0] misrStep(input logic [18:0] m, input logic [18:0] d);
        logic fb;
        fb = m[18] ^ m[5] ^ m[1] ^ m[0];
        return {m[17:0], fb} ^ d;
    endfunction

    function automatic logic [17:0] lfsrStep(input logic [17:0] l);
        return {l[16:0], l[17] ^ l[10]};
    endfunction

    // Stand-in CUT: purely combinational mix of the applied pattern
    function automatic logic [18:0] cutResp(input logic [17:0] p);
        return {p[0] ^ p[17], p} ^ {p[9:0], p[17:9]};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive start/reset, then advance to 1 time unit past the next rising edge
    task automatic applyStimulus(input logic stA, input logic stB, input logic stC,
                                 input logic rst);
        busA.start = stA;
        busB.start = stB;
        busC.start = stC;
        RST        = rst;
        @(posedge CK);
        #1;
    endtask

    task automatic runC(input string tag, input bit useCut, input int flipIdx,
                        input int abortIdx, input int midStartIdx, input bit checkHead);
        logic [17:0] lfsrM;
        int errs;
        lfsrM    = 18'h00001;
        modelSig = '0;
        errs     = 0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput({tag, "/init1"}, {busC.busy, busC.done, busC.pat_o}, {1'b1, 1'b0, 18'h20000});
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "/init2"}, {busC.busy, busC.done, busC.pat_o}, {1'b1, 1'b0, 18'h20000});
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NC; i++) begin
            if (i == abortIdx) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
                checkOutput({tag, "/abort"},
                            {busC.busy, busC.done, busC.pass, busC.pat_o, busC.signature, busC.pat_cnt},
                            64'h0);
                RST = 1'b0;
                busC.rsp_i = '0;
                return;
            end
            if (checkHead && i < 12) begin
                checkOutput($sformatf("%s/pat%0d", tag, i), busC.pat_o, HEAD_PAT[i]);
            end
            if (busC.pat_o !== lfsrM || busC.busy !== 1'b1 || busC.done !== 1'b0 ||
                busC.pass !== 1'b0 || busC.pat_cnt !== 16'(i)) begin
                errs++;
            end
            if (useCut) begin
                busC.rsp_i = cutResp(busC.pat_o);
            end else begin
                busC.rsp_i = (i == flipIdx) ? 19'h00010 : 19'h00000;
            end
            modelSig = misrStep(modelSig, busC.rsp_i);
            lfsrM    = lfsrStep(lfsrM);
            applyStimulus(1'b0, 1'b0, (i == midStartIdx), 1'b0);
        end
        busC.rsp_i = '0;
        checkOutput({tag, "/runSeq"}, errs, 0);
        checkOutput({tag, "/doneFlags"}, {busC.busy, busC.done, busC.pat_o}, {1'b0, 1'b1, 18'h0});
        checkOutput({tag, "/patCnt"}, busC.pat_cnt, 16'd1023);
        checkOutput({tag, "/sig"}, busC.signature, modelSig);
        checkOutput({tag, "/pass"}, busC.pass, (modelSig === 19'h0));
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        RST        = 1'b1;
        busA.start = 1'b0;
        busB.start = 1'b0;
        busC.start = 1'b0;
        busA.rsp_i = 19'h1;
        busB.rsp_i = 19'h1;
        busC.rsp_i = 19'h0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rstC",
                    {busC.busy, busC.done, busC.pass, busC.pat_o, busC.signature, busC.pat_cnt}, 64'h0);
        checkOutput("rstB/pass", {busB.done, busB.pass}, 2'b00);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("idle%0d", i),
                        {busC.busy, busC.done, busC.pass, busC.pat_o, busC.signature, busC.pat_cnt},
                        64'h0);
        end
        checkOutput("idleB/pass", busB.pass, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("short/c1", {busA.busy, busA.pat_o}, {1'b1, 18'h20000});
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("short/c3", {busA.busy, busA.pat_o, busA.pat_cnt}, {1'b1, 18'h00001, 16'd0});
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("short/c4", {busA.busy, busA.done, busA.pass, busA.pat_o},
                    {1'b1, 1'b0, 1'b0, 18'h00002});
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("shortA/c5", {busA.busy, busA.done, busA.pass, busA.signature, busA.pat_cnt},
                    {1'b0, 1'b1, 1'b1, 19'h00002, 16'd2});
        checkOutput("shortB/c5", {busB.done, busB.pass, busB.signature}, {1'b1, 1'b0, 19'h00002});

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("restartA/c1", {busA.busy, busA.done, busA.pass}, 3'b100);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("restartA/c5", {busA.done, busA.pass, busA.signature}, {1'b1, 1'b1, 19'h00002});

        runC("zero", 1'b0, -1, -1, 5, 1'b1);
        checkOutput("zero/sigConst", {busC.pass, busC.signature}, {1'b1, 19'h0});

        runC("flip", 1'b0, 100, -1, -1, 1'b0);
        checkOutput("flip/passLow", busC.pass, 1'b0);

        runC("cut", 1'b1, -1, -1, 700, 1'b0);
        refSig = modelSig;
        busC.rsp_i = 19'h7FFFF;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("cut/frozen", {busC.done, busC.signature, busC.pat_cnt}, {1'b1, refSig, 16'd1023});
        busC.rsp_i = '0;

        runC("abort", 1'b1, -1, 500, -1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("abort/idle", {busC.busy, busC.done, busC.pass, busC.pat_o}, 21'h0);

        runC("again", 1'b1, -1, -1, -1, 1'b0);
        checkOutput("again/sameSig", busC.signature, refSig);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
